inv_key_schedule_192: RTL and testbench
=======================================

INV_KEY_SCHEDULE_192 -- requirements
Module: inv_key_schedule_192

Interface
REQ-001 Parameter NK, default 6, key length in 32-bit words; only 6 is supported.
REQ-002 Parameter NR, default 12, number of rounds; only 12 is supported.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  request to expand key_in; sampled only in IDLE.
REQ-006 key_in  input  192  cipher key; key_in[191:160] is w0 and key_in[31:0] is w5.
REQ-007 busy  output  1  high in EXPAND and STREAM.
REQ-008 rk_valid  output  1  rk_out/rk_idx/rk_last hold a valid round key.
REQ-009 rk_ready  input  1  consumer accepts the round key when rk_valid and rk_ready are both high on an edge.
REQ-010 rk_out  output  128  round key {w[4r],w[4r+1],w[4r+2],w[4r+3]}; w[4r] is in rk_out[127:96].
REQ-011 rk_idx  output  4  round index r of rk_out.
REQ-012 rk_last  output  1  high with rk_valid when r=0.
REQ-013 done  output  1  one-cycle pulse after round key 0 is accepted.

Function
REQ-014 The FSM shall have states IDLE, EXPAND and STREAM.
REQ-015 Transitions: IDLE->EXPAND on start; EXPAND->STREAM after w51 is written; STREAM->IDLE on acceptance of r=0.
REQ-016 On the edge that samples start in IDLE, the block shall capture w0..w5 from key_in into a 52x32 word buffer and clear the word counter i to 6.
REQ-017 In EXPAND, the block shall compute and write exactly one word per cycle, for i=6..51, which is 46 cycles.
REQ-018 Word rule: temp=w[i-1]; if i mod 6 = 0, temp=SubWord(RotWord(temp)) XOR Rcon[i/6-1]; w[i]=w[i-6] XOR temp.
REQ-019 RotWord: {b[23:0],b[31:24]}.
REQ-020 SubWord: applies the FIPS-197 S-box to each byte.
REQ-021 Rcon[0..7] shall be 01,02,04,08,10,20,40,80 in bits [31:24], with zeros below.
REQ-022 The S-box shall be instantiated once and shared across bytes of one word only; there shall be no per-cycle multi-word expansion.
REQ-023 rk_valid shall rise on the edge after the one that writes w51, which is the 47th edge after the start edge, with rk_idx=12.
REQ-024 Round keys shall be presented in descending order r=12,11,...,0, which is 13 keys, for decryption use.
REQ-025 While rk_valid is high and rk_ready is low, rk_out, rk_idx and rk_last shall hold stable.
REQ-026 On acceptance of r>0, the next key (r-1) shall be valid on the following edge, sustaining one key per cycle when rk_ready is held high.
REQ-027 On acceptance of r=0, the block shall deassert rk_valid, return to IDLE, and pulse done for exactly one cycle.
REQ-028 start in EXPAND or STREAM shall be ignored, with no restart.
REQ-029 Changes on key_in after the start edge shall have no effect.
REQ-030 rk_ready while rk_valid is low shall have no effect.
REQ-031 start may be asserted in the same cycle as done, and shall be honoured because the FSM is already in IDLE.
REQ-032 rk_valid shall never be high in IDLE or EXPAND.

Reset
REQ-033 rst high shall force, immediately and independently of clk: state IDLE; busy, rk_valid, rk_last and done = 0; rk_out = 0; rk_idx = 0; counters = 0.
REQ-034 Assertion of rst mid-EXPAND or mid-STREAM shall abort the operation; the buffer contents are don't-care afterwards.
REQ-035 The first start after rst deasserts shall run a full expansion.

Verification
REQ-036 Bench: key_in=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, start pulse, rk_ready=1 -> after 47 edges rk_valid=1, rk_idx=12, rk_out=e98ba06f448c773c8ecc720401002202.
REQ-037 Bench: same run -> rk_idx=1 gives rk_out=62f8ead2522c6b7bfe0c91f72402f5a5; rk_idx=0 gives rk_out=8e73b0f7da0e6452c810f32b809079e5 with rk_last=1; then a done pulse; 13 keys total on consecutive cycles.
REQ-038 Bench: rk_ready toggled randomly -> identical 13-key sequence, with outputs stable during every stall.
REQ-039 Bench: start re-pulsed during EXPAND and during STREAM, and key_in changed after start -> output sequence unchanged from REQ-036/037.
REQ-040 Bench: rst asserted asynchronously at EXPAND cycle 20 and at STREAM key r=5 -> all outputs 0 before the next clk edge; a fresh start then yields the REQ-036 result.
REQ-041 Bench: all-zero key -> rk_idx=12 key matches the FIPS-197 reference model; start in the done cycle launches a new expansion.

Source files
------------

// File: rtl/inv_key_schedule_192.sv
// AES-192 key expansion that streams round keys in reverse order (r=12..0)
// for an equivalent-inverse decryption datapath.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign s = TABLE[11'd2047 - {a, 3'b000} -: 8];
endmodule

module inv_key_schedule_192 #(
  parameter int NK = 6,
  parameter int NR = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [191:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         done
);
  localparam int NW = 4 * (NR + 1);

  typedef enum logic [1:0] {IDLE, EXPAND, STREAM} state_t;
  state_t state, state_nxt;

  logic [31:0] w [NW];
  logic [5:0]  i;
  logic [2:0]  phase;   // i mod 6, tracked incrementally
  logic [2:0]  rc;      // Rcon index, i/6-1 when phase==0

  logic [31:0] prev, rot, sub, temp, new_w;
  logic [7:0]  rcon;
  logic        accept, last_word;
  logic [3:0]  sel_r;
  logic [5:0]  base;
  logic [127:0] rk_sel;

  assign prev = w[i - 6'd1];
  assign rot  = {prev[23:0], prev[31:24]};

  // one SubWord unit: four byte lookups of a single word per cycle
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (.a(rot[8*b +: 8]), .s(sub[8*b +: 8]));
  end

  assign rcon  = 8'h01 << rc;
  assign temp  = (phase == 3'd0) ? (sub ^ {rcon, 24'h0}) : prev;
  assign new_w = w[i - 6'(NK)] ^ temp;

  assign accept    = rk_valid && rk_ready;
  assign last_word = (i == 6'(NW - 1));
  assign busy      = (state != IDLE);

  // first load presents r=NR; afterwards each acceptance steps down by one
  assign sel_r  = rk_valid ? (rk_idx - 4'd1) : 4'(NR);
  assign base   = {sel_r, 2'b00};
  assign rk_sel = {w[base], w[base + 6'd1], w[base + 6'd2], w[base + 6'd3]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = EXPAND;
      EXPAND:  if (last_word) state_nxt = STREAM;
      STREAM:  if (accept && rk_idx == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i        <= '0;
      phase    <= '0;
      rc       <= '0;
      rk_valid <= 1'b0;
      rk_out   <= '0;
      rk_idx   <= '0;
      rk_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          i     <= 6'(NK);
          phase <= '0;
          rc    <= '0;
        end
        EXPAND: begin
          i     <= i + 6'd1;
          phase <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
          if (phase == 3'd0) rc <= rc + 3'd1;
        end
        STREAM: begin
          if (!rk_valid) begin
            rk_valid <= 1'b1;
            rk_out   <= rk_sel;
            rk_idx   <= 4'(NR);
            rk_last  <= 1'b0;
          end else if (accept) begin
            if (rk_idx == 4'd0) begin
              rk_valid <= 1'b0;
              rk_last  <= 1'b0;
              done     <= 1'b1;
            end else begin
              rk_out  <= rk_sel;
              rk_idx  <= rk_idx - 4'd1;
              rk_last <= (rk_idx == 4'd1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  // word buffer carries no reset; contents are rebuilt on every start
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      for (int j = 0; j < NK; j++) w[j] <= key_in[32*(NK-1-j) +: 32];
    end else if (state == EXPAND) begin
      w[i] <= new_w;
    end
  end
endmodule

// File: tb/tb_inv_key_schedule_192.sv
// Directed bench for inv_key_schedule_192 with an independent AES-192 key model.
module tb_inv_key_schedule_192;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [191:0] key_in = '0;
  logic         busy, rk_valid, rk_last, done;
  logic         rk_ready = 1'b0;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;

  inv_key_schedule_192 #(.NK(6), .NR(12)) dut (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_out(rk_out), .rk_idx(rk_idx),
    .rk_last(rk_last), .done(done)
  );

  always #5 clk = ~clk;

  localparam logic [191:0] KEY_A = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [127:0] A_RK12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] A_RK1  = 128'h62f8ead2522c6b7bfe0c91f72402f5a5;
  localparam logic [127:0] A_RK0  = 128'h8e73b0f7da0e6452c810f32b809079e5;

  typedef struct {
    logic [191:0] key;
    int           rmode;
    bit           disturb;
    logic [127:0] rk12, rk1, rk0;
  } vec_t;

  vec_t vt[3];
  int tests = 0;
  int fails = 0;

  logic [7:0]   sb_m [256];
  logic [31:0]  mw [52];
  logic [127:0] got_rk [16];
  logic         got_last [16];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv, x;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      x = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb_m[v] = x;
    end
  endtask

  task automatic model_fill(input logic [191:0] k);
    logic [7:0]  rcon_m [8];
    logic [31:0] t;
    rcon_m = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    for (int j = 0; j < 6; j++) mw[j] = k[191 - 32*j -: 32];
    for (int j = 6; j < 52; j++) begin
      t = mw[j-1];
      if (j % 6 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb_m[t[31:24]], sb_m[t[23:16]], sb_m[t[15:8]], sb_m[t[7:0]]};
        t = t ^ {rcon_m[j/6 - 1], 24'h0};
      end
      mw[j] = mw[j-6] ^ t;
    end
  endtask

  task automatic verify(input logic [191:0] k, input string tag);
    model_fill(k);
    for (int r = 0; r < 13; r++) begin
      chk($sformatf("%s_rk%0d", tag, r), got_rk[r], {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]});
      chk($sformatf("%s_last%0d", tag, r), 192'(got_last[r]), 192'(r == 0));
    end
  endtask

  task automatic do_abort();
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", 192'(busy), 192'(0));
    chk("rst_valid", 192'(rk_valid), 192'(0));
    chk("rst_last", 192'(rk_last), 192'(0));
    chk("rst_done", 192'(done), 192'(0));
    chk("rst_out", 192'(rk_out), 192'(0));
    chk("rst_idx", 192'(rk_idx), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    rk_ready = 1'b0;
  endtask

  // Runs one expansion/stream, sampling on negedges; collects accepted keys into got_rk.
  task automatic run(input logic [191:0] k, input int rmode, input bit disturb,
                     input int abort_mode, input bit skip_start, input bit chain,
                     input logic [191:0] chain_key);
    int n, scyc, expn;
    bit pv, pr, got0;
    logic [127:0] po;
    logic [3:0] pi;
    logic pl;
    for (int r = 0; r < 16; r++) begin got_rk[r] = '0; got_last[r] = 1'b0; end
    if (!skip_start) begin
      @(negedge clk);
      key_in = k; start = 1'b1; rk_ready = (rmode == 0);
      @(negedge clk);
      start = 1'b0;
    end
    if (disturb) key_in = ~k;
    chk("busy_after_start", 192'(busy), 192'(1));
    n = 0;
    while (!rk_valid && n < 60) begin
      if (abort_mode == 1 && n == 20) begin do_abort(); return; end
      start = disturb && (n == 10);
      rk_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("first_key_latency", 192'(n), 192'(47));
    expn = 12; pv = 0; pr = 0; po = '0; pi = '0; pl = 1'b0; scyc = 0; got0 = 0;
    while (!got0 && scyc < 200) begin
      if (pv && !pr) begin
        chk("stall_out", 192'(rk_out), 192'(po));
        chk("stall_idx", 192'(rk_idx), 192'(pi));
        chk("stall_last", 192'(rk_last), 192'(pl));
      end
      if (!rk_valid) begin
        chk("valid_held", 192'(rk_valid), 192'(1));
        break;
      end
      if (abort_mode == 2 && rk_idx == 4'd5) begin do_abort(); return; end
      start = disturb && (scyc == 0);
      rk_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      pv = 1; pr = rk_ready; po = rk_out; pi = rk_idx; pl = rk_last;
      if (rk_ready) begin
        chk("key_order", 192'(rk_idx), 192'(expn));
        got_rk[rk_idx] = rk_out;
        got_last[rk_idx] = rk_last;
        got0 = (rk_idx == 4'd0);
        expn--;
      end
      @(negedge clk);
      scyc++;
    end
    start = 1'b0;
    chk("stream_complete", 192'(got0), 192'(1));
    if (rmode == 0) chk("back_to_back_cycles", 192'(scyc), 192'(13));
    chk("done_pulse", 192'(done), 192'(1));
    chk("valid_after_last", 192'(rk_valid), 192'(0));
    chk("idle_after_last", 192'(busy), 192'(0));
    if (chain) begin
      key_in = chain_key; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end else begin
      @(negedge clk);
      chk("done_one_cycle", 192'(done), 192'(0));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    build_sbox();
    vt[0] = '{KEY_A, 0, 1'b0, A_RK12, A_RK1, A_RK0};
    vt[1] = '{KEY_A, 1, 1'b0, A_RK12, A_RK1, A_RK0};
    vt[2] = '{KEY_A, 0, 1'b1, A_RK12, A_RK1, A_RK0};

    #1 rst = 1'b1;
    #2;
    chk("reset_busy", 192'(busy), 192'(0));
    chk("reset_valid", 192'(rk_valid), 192'(0));
    chk("reset_done", 192'(done), 192'(0));
    chk("reset_out", 192'(rk_out), 192'(0));
    chk("reset_idx", 192'(rk_idx), 192'(0));
    @(negedge clk);
    rst = 1'b0;
    chk("sbox_model_63", 192'(sb_m[0]), 192'(8'h63));

    for (int t = 0; t < 3; t++) begin
      run(vt[t].key, vt[t].rmode, vt[t].disturb, 0, 1'b0, 1'b0, '0);
      chk($sformatf("vec%0d_rk12", t), got_rk[12], vt[t].rk12);
      chk($sformatf("vec%0d_rk1", t), got_rk[1], vt[t].rk1);
      chk($sformatf("vec%0d_rk0", t), got_rk[0], vt[t].rk0);
      verify(vt[t].key, $sformatf("vec%0d", t));
    end

    run(KEY_A, 0, 1'b0, 1, 1'b0, 1'b0, '0);
    run(KEY_A, 0, 1'b0, 0, 1'b0, 1'b0, '0);
    chk("after_expand_abort_rk12", got_rk[12], A_RK12);
    verify(KEY_A, "post_abort1");

    run(KEY_A, 0, 1'b0, 2, 1'b0, 1'b0, '0);
    run(KEY_A, 0, 1'b0, 0, 1'b0, 1'b0, '0);
    chk("after_stream_abort_rk12", got_rk[12], A_RK12);
    verify(KEY_A, "post_abort2");

    run('0, 0, 1'b0, 0, 1'b0, 1'b1, KEY_A);
    verify('0, "zero_key");
    run(KEY_A, 0, 1'b0, 0, 1'b1, 1'b0, '0);
    chk("chained_rk12", got_rk[12], A_RK12);
    verify(KEY_A, "chained");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
